// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per PC_WRITE rising edge over a
// req/ack memory port, latches it into the IR and applies branch decisions.
module fetch_unit #(
    parameter int PC_W     = 16,
    parameter int IR_W     = 32,
    parameter int TIMEOUT  = 15,
    parameter int RESET_PC = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PC_WRITE,
    input  logic            BR_LOAD,
    input  logic            PC_SEL,
    input  logic            BR_SEL,
    input  logic [IR_W-1:0] IMEM_RDATA,
    input  logic            IMEM_ACK,
    output logic            IMEM_REQ,
    output logic [PC_W-1:0] IMEM_ADDR,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] IR_PC,
    output logic [3:0]      OPCODE,
    output logic [3:0]      MM,
    output logic [15:0]     IMM,
    output logic            IR_VALID,
    output logic            BUSY,
    output logic            FETCH_ERR,
    output logic            HALTED,
    output logic [1:0]      DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
    localparam logic [7:0]      TO_M1  = 8'(TIMEOUT - 1);
    localparam logic [3:0]      OP_HLT = 4'hF;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        wait_q, wait_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              ir_valid_q, ir_valid_d;
    logic              err_q, err_d;
    logic              halted_q, halted_d;
    logic              pcw_prev_q;

    logic              fetch_edge;
    logic              br_take;
    logic [31:0]       imm_sext;
    logic [31:0]       imm_zext;
    logic [PC_W-1:0]   br_target;

    // Memory handshake: IMEM_REQ rises with IMEM_ADDR and both hold steady until the cycle
    // IMEM_ACK=1 is sampled (transfer complete, IMEM_RDATA valid) or the wait budget runs out.
    assign fetch_edge = PC_WRITE & ~pcw_prev_q;
    assign br_take    = BR_LOAD & PC_SEL;
    assign imm_sext   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext   = {16'h0000, ir_q[15:0]};
    assign br_target  = BR_SEL ? (ir_pc_q + imm_sext[PC_W-1:0]) : imm_zext[PC_W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            pc_q         <= RST_PC;
            ir_q         <= '0;
            ir_pc_q      <= '0;
            addr_q       <= '0;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            wait_q       <= '0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            ir_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            halted_q     <= 1'b0;
            pcw_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            addr_q       <= addr_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            wait_q       <= wait_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            ir_valid_q   <= ir_valid_d;
            err_q        <= err_d;
            halted_q     <= halted_d;
            pcw_prev_q   <= PC_WRITE;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;
        addr_d       = addr_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        wait_d       = wait_q;
        req_d        = req_q;
        busy_d       = busy_q;
        ir_valid_d   = ir_valid_q;
        err_d        = err_q;
        halted_d     = halted_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_edge) begin
                    // A branch arriving with the fetch edge waits for the fetch to finish.
                    state_d      = S_FETCH;
                    req_d        = 1'b1;
                    addr_d       = pc_q;
                    busy_d       = 1'b1;
                    ir_valid_d   = 1'b0;
                    wait_d       = '0;
                    pend_valid_d = br_take;
                    pend_pc_d    = br_target;
                end else if (br_take) begin
                    pc_d = br_target;
                end
            end
            S_FETCH: begin
                if (BR_LOAD) begin
                    pend_valid_d = PC_SEL;
                    pend_pc_d    = br_target;
                end
                if (IMEM_ACK) begin
                    ir_d         = IMEM_RDATA;
                    ir_pc_d      = addr_q;
                    ir_valid_d   = 1'b1;
                    err_d        = 1'b0;
                    pc_d         = pend_valid_d ? pend_pc_d : addr_q + 1'b1;
                    pend_valid_d = 1'b0;
                    req_d        = 1'b0;
                    busy_d       = 1'b0;
                    wait_d       = '0;
                    if (IMEM_RDATA[31:28] == OP_HLT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else if (wait_q == TO_M1) begin
                    // Abort: IR and PC keep their old values, any pending branch is dropped.
                    state_d      = S_IDLE;
                    req_d        = 1'b0;
                    busy_d       = 1'b0;
                    err_d        = 1'b1;
                    ir_valid_d   = 1'b0;
                    pend_valid_d = 1'b0;
                    wait_d       = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_HALT: begin
                req_d    = 1'b0;
                busy_d   = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = addr_q;
    assign PC        = pc_q;
    assign IR_PC     = ir_pc_q;
    assign OPCODE    = ir_q[31:28];
    assign MM        = ir_q[27:24];
    assign IMM       = ir_q[15:0];
    assign IR_VALID  = ir_valid_q;
    assign BUSY      = busy_q;
    assign FETCH_ERR = err_q;
    assign HALTED    = halted_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a scoreboard that checks every
// instruction landing in the IR against the word the bench handed to the memory port.
module tb_fetch_unit;

    localparam int TIMEOUT = 15;
    localparam int W       = 40;  // {OPCODE, MM, IMM, IR_PC}

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PC_WRITE = 1'b0;
    logic        BR_LOAD = 1'b0;
    logic        PC_SEL = 1'b0;
    logic        BR_SEL = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        IMEM_ACK = 1'b0;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic [15:0] PC;
    logic [15:0] IR_PC;
    logic [3:0]  OPCODE;
    logic [3:0]  MM;
    logic [15:0] IMM;
    logic        IR_VALID;
    logic        BUSY;
    logic        FETCH_ERR;
    logic        HALTED;
    logic [1:0]  DBG_STATE;

    int checks = 0;
    int failures = 0;
    int req_rises = 0;
    logic [W-1:0] exp_q[$];
    logic ivp = 1'b0;
    logic rqp = 1'b0;

    fetch_unit #(.PC_W(16), .IR_W(32), .TIMEOUT(TIMEOUT), .RESET_PC(0)) dut (
        .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .BR_LOAD(BR_LOAD), .PC_SEL(PC_SEL),
        .BR_SEL(BR_SEL), .IMEM_RDATA(IMEM_RDATA), .IMEM_ACK(IMEM_ACK), .IMEM_REQ(IMEM_REQ),
        .IMEM_ADDR(IMEM_ADDR), .PC(PC), .IR_PC(IR_PC), .OPCODE(OPCODE), .MM(MM), .IMM(IMM),
        .IR_VALID(IR_VALID), .BUSY(BUSY), .FETCH_ERR(FETCH_ERR), .HALTED(HALTED),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_pc_write();
        PC_WRITE = 1'b1;
        tick();
        PC_WRITE = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] data, input logic [15:0] addr);
        IMEM_RDATA = data;
        IMEM_ACK   = 1'b1;
        exp_q.push_back({data[31:28], data[27:24], data[15:0], addr});
        tick();
        IMEM_ACK   = 1'b0;
        IMEM_RDATA = $urandom;
    endtask

    task automatic fetch(input logic [31:0] data, input int waits, input logic [15:0] addr);
        pulse_pc_write();
        repeat (waits) tick();
        ack_now(data, addr);
    endtask

    task automatic branch(input logic pc_sel, input logic br_sel);
        BR_LOAD = 1'b1;
        PC_SEL  = pc_sel;
        BR_SEL  = br_sel;
        tick();
        BR_LOAD = 1'b0;
        PC_SEL  = 1'b0;
        BR_SEL  = 1'b0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge CLK) begin
        if (IR_VALID === 1'b1 && ivp == 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ir got=%h%h%h ir_pc=%h exp=none", OPCODE, MM, IMM, IR_PC);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({OPCODE, MM, IMM, IR_PC} !== e) begin
                    failures++;
                    $display("FAIL sb_ir got=%h exp=%h", {OPCODE, MM, IMM, IR_PC}, e);
                end
            end
        end
        if (IMEM_REQ === 1'b1 && rqp == 1'b0) req_rises++;
        ivp = (IR_VALID === 1'b1);
        rqp = (IMEM_REQ === 1'b1);
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (PC !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", PC); end
        checks++; if ({IMEM_REQ, BUSY, IR_VALID, FETCH_ERR, HALTED} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {IMEM_REQ, BUSY, IR_VALID, FETCH_ERR, HALTED});
        end
        checks++; if ({OPCODE, MM, IMM, IR_PC} !== 40'h0) begin
            failures++; $display("FAIL reset_ir got=%h exp=0", {OPCODE, MM, IMM, IR_PC});
        end
        checks++; if (DBG_STATE !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", DBG_STATE); end
    endtask

    task automatic test_basic_fetch();
        pulse_pc_write();
        checks++; if ({IMEM_REQ, BUSY, IR_VALID} !== 3'b110 || IMEM_ADDR !== 16'h0000) begin
            failures++; $display("FAIL basic_req got req/busy/irv=%b addr=%h exp=110 addr=0000", {IMEM_REQ, BUSY, IR_VALID}, IMEM_ADDR);
        end
        ack_now(32'h8100_0005, 16'h0000);
        checks++; if (IR_VALID !== 1'b1 || OPCODE !== 4'h8 || MM !== 4'h1 || IMM !== 16'h0005) begin
            failures++; $display("FAIL basic_ir got v=%b op=%h mm=%h imm=%h exp v=1 op=8 mm=1 imm=0005", IR_VALID, OPCODE, MM, IMM);
        end
        checks++; if (IR_PC !== 16'h0000 || PC !== 16'h0001) begin
            failures++; $display("FAIL basic_pc got ir_pc=%h pc=%h exp 0000 0001", IR_PC, PC);
        end
        checks++; if ({IMEM_REQ, BUSY} !== 2'b00) begin
            failures++; $display("FAIL basic_done got req/busy=%b exp=00", {IMEM_REQ, BUSY});
        end
    endtask

    task automatic test_held_pc_write();
        int rises0;
        logic stable;
        rises0 = req_rises;
        stable = 1'b1;
        PC_WRITE = 1'b1;
        tick();
        if (IMEM_ADDR !== 16'h0001 || IMEM_REQ !== 1'b1) stable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) PC_WRITE = 1'b0;
            tick();
            if (IMEM_ADDR !== 16'h0001 || IMEM_REQ !== 1'b1) stable = 1'b0;
        end
        ack_now({4'h2, 28'($urandom)}, 16'h0001);
        repeat (3) tick();
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL held_addr_stable got=%b exp=1", stable); end
        checks++; if (req_rises - rises0 != 1) begin
            failures++; $display("FAIL held_req_episodes got=%0d exp=1", req_rises - rises0);
        end
        checks++; if (PC !== 16'h0002 || IMEM_REQ !== 1'b0) begin
            failures++; $display("FAIL held_pc got pc=%h req=%b exp 0002 0", PC, IMEM_REQ);
        end
    endtask

    task automatic test_branch();
        fetch(32'h1000_0010, 0, 16'h0002);
        branch(1'b1, 1'b0);
        checks++; if (PC !== 16'h0010) begin failures++; $display("FAIL br_abs_setup got=%h exp=0010", PC); end
        fetch(32'h2000_FFFC, 1, 16'h0010);
        branch(1'b1, 1'b1);
        checks++; if (PC !== 16'h000C) begin failures++; $display("FAIL br_rel_neg got=%h exp=000C", PC); end
        branch(1'b0, 1'b0);
        checks++; if (PC !== 16'h000C) begin failures++; $display("FAIL br_not_taken got=%h exp=000C", PC); end
        fetch(32'h3000_0040, 2, 16'h000C);
        branch(1'b1, 1'b0);
        checks++; if (PC !== 16'h0040) begin failures++; $display("FAIL br_abs got=%h exp=0040", PC); end
    endtask

    task automatic test_branch_mid_fetch();
        int cnt;
        fetch(32'h4000_0100, 0, 16'h0040);
        pulse_pc_write();
        tick();
        branch(1'b1, 1'b0);
        ack_now(32'h5000_0200, 16'h0041);
        checks++; if (PC !== 16'h0100 || IR_PC !== 16'h0041) begin
            failures++; $display("FAIL mid_br_ack got pc=%h ir_pc=%h exp 0100 0041", PC, IR_PC);
        end
        // second fetch: branch pending to 0x0200, memory never answers
        pulse_pc_write();
        cnt = 0;
        while (IMEM_REQ === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 1) begin BR_LOAD = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'b0; end
            tick();
            BR_LOAD = 1'b0;
            PC_SEL  = 1'b0;
        end
        checks++; if (cnt != TIMEOUT) begin failures++; $display("FAIL timeout_len got=%0d exp=%0d", cnt, TIMEOUT); end
        checks++; if ({FETCH_ERR, IR_VALID, BUSY} !== 3'b100 || PC !== 16'h0100) begin
            failures++; $display("FAIL timeout_state got err/irv/busy=%b pc=%h exp 100 0100", {FETCH_ERR, IR_VALID, BUSY}, PC);
        end
        fetch(32'h6000_0007, 0, 16'h0100);
        checks++; if (PC !== 16'h0101 || FETCH_ERR !== 1'b0) begin
            failures++; $display("FAIL pend_dropped got pc=%h err=%b exp 0101 0", PC, FETCH_ERR);
        end
    endtask

    task automatic test_wrap();
        fetch(32'h7000_FFFF, 0, 16'h0101);
        branch(1'b1, 1'b0);
        checks++; if (PC !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup got=%h exp=FFFF", PC); end
        fetch(32'h8000_0001, 2, 16'hFFFF);
        checks++; if (PC !== 16'h0000 || IR_PC !== 16'hFFFF) begin
            failures++; $display("FAIL wrap_pc got pc=%h ir_pc=%h exp 0000 FFFF", PC, IR_PC);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] model_pc;
        model_pc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            w = {4'($urandom_range(0, 14)), 28'($urandom)};
            fetch(w, $urandom_range(0, 5), model_pc);
            model_pc = model_pc + 16'h0001;
            checks++; if (PC !== model_pc) begin
                failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, PC, model_pc);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        pulse_pc_write();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        IMEM_RDATA = 32'h9000_0000;
        IMEM_ACK   = 1'b1;
        tick();
        IMEM_ACK   = 1'b0;
        tick();
        checks++; if (DBG_STATE !== 2'd0 || PC !== 16'h0000 || IR_VALID !== 1'b0) begin
            failures++; $display("FAIL rst_mid got state=%0d pc=%h irv=%b exp 0 0000 0", DBG_STATE, PC, IR_VALID);
        end
        checks++; if ({IMEM_REQ, BUSY} !== 2'b00 || {OPCODE, IR_PC} !== 20'h0) begin
            failures++; $display("FAIL rst_mid_late_ack got req/busy=%b op=%h ir_pc=%h exp 00 0 0000", {IMEM_REQ, BUSY}, OPCODE, IR_PC);
        end
    endtask

    task automatic test_halt();
        int rises0;
        fetch(32'hF000_0000, 1, 16'h0000);
        checks++; if (HALTED !== 1'b1 || DBG_STATE !== 2'd2 || OPCODE !== 4'hF || PC !== 16'h0001) begin
            failures++; $display("FAIL halt_enter got h=%b st=%0d op=%h pc=%h exp 1 2 F 0001", HALTED, DBG_STATE, OPCODE, PC);
        end
        rises0 = req_rises;
        pulse_pc_write();
        tick();
        branch(1'b1, 1'b0);
        repeat (3) tick();
        checks++; if (req_rises != rises0 || IMEM_REQ !== 1'b0 || PC !== 16'h0001) begin
            failures++; $display("FAIL halt_frozen got rises=%0d req=%b pc=%h exp 0 0 0001", req_rises - rises0, IMEM_REQ, PC);
        end
        checks++; if (HALTED !== 1'b1 || IR_VALID !== 1'b1 || OPCODE !== 4'hF) begin
            failures++; $display("FAIL halt_hold got h=%b irv=%b op=%h exp 1 1 F", HALTED, IR_VALID, OPCODE);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_held_pc_write();
        test_branch();
        test_branch_mid_fetch();
        test_wrap();
        test_back_to_back();
        test_reset_mid_fetch();
        test_halt();
        tick();
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
